pingpong_buf_reader: RTL and testbench
======================================

Name: pingpong_buf_reader

Overview:
- Read-side controller for the ping-pong SP RAM.
- On each buffer-ready pulse, sweeps addresses 0..SAMPLES_PER_BUF-1 of the inactive buffer over the RAM's 1-cycle-latency read port.
- Re-emits the samples as a valid/ready stream with last-sample and buffer-id tagging.
- Absorbs downstream backpressure with a 2-entry skid FIFO and flags overruns when a new buffer completes before the current drain finishes.

Parameters:
- DATA_WIDTH, 16, sample width.
- SAMPLES_PER_BUF, 256, samples per buffer; must be a power of two ≥ 2.
- ADDR_WIDTH, $clog2(SAMPLES_PER_BUF), read address width.

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, synchronous active-high reset.
- buf_ready_pulse_i, input, 1, one-cycle pulse: a buffer has been filled.
- buf_ready_id_i, input, 1, id of the filled buffer; valid with the pulse.
- rd_en_o, output, 1, RAM read request.
- rd_addr_o, output, ADDR_WIDTH, RAM read address.
- rd_data_i, input, DATA_WIDTH, RAM read data; 1 cycle after rd_en_o.
- rd_valid_i, input, 1, RAM read-data valid; 1 cycle after rd_en_o.
- out_valid_o, output, 1, stream sample valid.
- out_ready_i, input, 1, downstream ready.
- out_data_o, output, DATA_WIDTH, stream sample.
- out_last_o, output, 1, high with the sample from address SAMPLES_PER_BUF-1.
- out_buf_id_o, output, 1, id of the buffer the current sample came from.
- busy_o, output, 1, drain in progress (state ≠ IDLE).
- done_pulse_o, output, 1, one-cycle pulse on the handshake of the last sample.
- overrun_pulse_o, output, 1, one-cycle pulse when a ready pulse is dropped.
- overrun_sticky_o, output, 1, latched overrun; cleared only by reset.

Behaviour:
- Reset: all outputs 0; FIFO emptied; address counter 0; in-flight flag 0; state IDLE.
- Reset mid-drain aborts immediately. Any RAM data returning in the cycle after reset is discarded.
- Handshake: a transfer occurs when out_valid_o && out_ready_i.
  - out_data_o, out_last_o and out_buf_id_o reflect the FIFO head and are held stable while out_valid_o=1 and out_ready_i=0.
  - out_valid_o never drops without a transfer.
- States:
  - IDLE: on buf_ready_pulse_i, latch buf_ready_id_i into cur_id, clear the address counter, go to ISSUE.
  - ISSUE: issue reads until address SAMPLES_PER_BUF-1 has been issued, then go to FLUSH.
  - FLUSH: wait until no read is in flight and the FIFO is empty. Then go to IDLE, or directly to ISSUE if a ready pulse arrives that same cycle (id latched, counter cleared).
- Issue rule: rd_en_o=1 in ISSUE only when (fifo_count + inflight − pop_this_cycle) < 2. rd_addr_o = address counter, which increments on each issued read. rd_addr_o holds its last value when rd_en_o=0.
- Return path: rd_valid_i pushes {rd_data_i, last flag, cur_id} into the FIFO.
  - The last flag is registered alongside the issued address, true when the address was SAMPLES_PER_BUF-1.
  - inflight is a 1-bit register: set on issue, cleared on return.
- Throughput: with out_ready_i held 1, one sample per cycle sustained, no bubbles after the first.
- Latency: pulse sampled at edge N.
  - rd_en_o=1 with address 0 during cycle N+1.
  - out_valid_o=1 with sample 0 during cycle N+2.
- done_pulse_o: asserted the cycle the out_last_o sample transfers.
- Overrun: buf_ready_pulse_i while in ISSUE, or in FLUSH other than the completing cycle:
  - pulse is dropped;
  - overrun_pulse_o=1 the next cycle;
  - overrun_sticky_o set;
  - the current drain continues unaffected.
- Address counter is ADDR_WIDTH bits. Wrap after SAMPLES_PER_BUF-1 is never used for issue: ISSUE exits first.

Test Plan:
- Reset, then pulse with id=0, out_ready_i=1, RAM model returns 0xA000+addr → 256 transfers 0xA000..0xA0FF on consecutive cycles; out_last_o only on 0xA0FF; out_buf_id_o=0; done_pulse_o once; first out_valid_o two cycles after the pulse.
- Same as above, but out_ready_i toggles with pseudo-random pattern (~50%) → every value 0xA000..0xA0FF delivered exactly once and in order; data stable during stalls; rd_en_o never lets FIFO+in-flight exceed 2.
- out_ready_i held 0 for 20 cycles mid-drain → rd_en_o deasserts once 2 samples are buffered; on release, stream resumes with no loss or duplicate.
- Pulse id=1 (data 0xB000+addr) arrives in the same cycle the id=0 last sample transfers → no idle gap; next sample 0xB000 with out_buf_id_o=1; no overrun.
- Second pulse at sample 100 of a drain → overrun_pulse_o for 1 cycle; overrun_sticky_o=1; current drain completes all 256 samples; no second drain starts.
- Assert rst_i at sample 50 → next cycle all outputs 0, state IDLE, sticky cleared; a subsequent pulse drains cleanly from address 0.

Source files
------------

// File: rtl/pingpong_buf_reader.sv
// Read-side controller for the ping-pong RAM: sweeps the filled buffer over a 1-cycle read port
// and re-emits the samples as a tagged valid/ready stream through a 2-entry skid FIFO.
module pingpong_buf_reader #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned SAMPLES_PER_BUF = 256,
  parameter int unsigned ADDR_WIDTH      = $clog2(SAMPLES_PER_BUF)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  buf_ready_pulse_i,
  input  logic                  buf_ready_id_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  rd_valid_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  out_buf_id_o,
  output logic                  busy_o,
  output logic                  done_pulse_o,
  output logic                  overrun_pulse_o,
  output logic                  overrun_sticky_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(SAMPLES_PER_BUF - 1);
  localparam int unsigned EntryW = DATA_WIDTH + 2;

  logic [1:0]            state_q, state_d;
  logic                  cur_id_q, cur_id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                  inflight_q, inflight_d;
  logic                  last_pend_q, last_pend_d;
  logic [EntryW-1:0]     fifo_q [2];
  logic [EntryW-1:0]     fifo_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  sticky_q, sticky_d;

  logic                  ret;
  logic [EntryW-1:0]     in_entry;
  logic [EntryW-1:0]     head;
  logic                  valid;
  logic                  pop;
  logic                  pop_fifo;
  logic                  store;
  logic [2:0]            occ;
  logic                  rd_en;
  logic                  flush_done;

  always_comb begin
    // Gating on inflight_q discards any read data that lands right after a reset.
    ret      = rd_valid_i && inflight_q;
    in_entry = {rd_data_i, last_pend_q, cur_id_q};
    // An empty FIFO falls through so sample 0 appears the cycle it returns from the RAM.
    head     = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : in_entry;
    valid    = (count_q != 2'd0) || ret;
    pop      = valid && out_ready_i;
    pop_fifo = pop && (count_q != 2'd0);
    store    = ret && !((count_q == 2'd0) && pop);
    occ      = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    rd_en    = (state_q == StIssue) && (occ < 3'd2);

    inflight_d  = rd_en ? 1'b1 : (ret ? 1'b0 : inflight_q);
    count_d     = count_q + 2'(store) - 2'(pop_fifo);
    wr_ptr_d    = wr_ptr_q ^ store;
    rd_ptr_d    = rd_ptr_q ^ pop_fifo;
    fifo_d      = fifo_q;
    if (store) fifo_d[wr_ptr_q] = in_entry;

    addr_d      = rd_en ? addr_q + ADDR_WIDTH'(1) : addr_q;
    last_addr_d = rd_en ? addr_q : last_addr_q;
    last_pend_d = rd_en ? (addr_q == LastAddr) : last_pend_q;

    // Completes in the cycle the final sample leaves, so a pulse then chains without a gap.
    flush_done = (state_q == StFlush) && !inflight_d && (count_d == 2'd0);

    state_d  = state_q;
    cur_id_d = cur_id_q;
    case (state_q)
      StIdle: begin
        if (buf_ready_pulse_i) begin
          state_d  = StIssue;
          cur_id_d = buf_ready_id_i;
          addr_d   = '0;
        end
      end
      StIssue: begin
        if (rd_en && (addr_q == LastAddr)) state_d = StFlush;
      end
      StFlush: begin
        if (flush_done) begin
          if (buf_ready_pulse_i) begin
            state_d  = StIssue;
            cur_id_d = buf_ready_id_i;
            addr_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    overrun_d = buf_ready_pulse_i &&
                ((state_q == StIssue) || ((state_q == StFlush) && !flush_done));
    sticky_d  = sticky_q || overrun_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cur_id_q    <= 1'b0;
      addr_q      <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      last_pend_q <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      overrun_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_id_q    <= cur_id_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      inflight_q  <= inflight_d;
      last_pend_q <= last_pend_d;
      fifo_q[0]   <= fifo_d[0];
      fifo_q[1]   <= fifo_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      sticky_q    <= sticky_d;
    end
  end

  assign rd_en_o          = rd_en;
  assign rd_addr_o        = rd_en ? addr_q : last_addr_q;
  assign out_valid_o      = valid;
  assign out_data_o       = valid ? head[EntryW-1:2] : '0;
  assign out_last_o       = valid & head[1];
  assign out_buf_id_o     = valid & head[0];
  assign busy_o           = (state_q != StIdle);
  assign done_pulse_o     = pop & head[1];
  assign overrun_pulse_o  = overrun_q;
  assign overrun_sticky_o = sticky_q;

endmodule

// File: tb/tb_pingpong_buf_reader.sv
// Scoreboard bench for pingpong_buf_reader: stimulus queues expected samples, a negedge monitor
// pops and compares them on every stream handshake.
module tb_pingpong_buf_reader;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 256;
  localparam int unsigned AW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic          id;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          pulse = 1'b0;
  logic          pulse_id = 1'b0;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [DW-1:0] rd_data = '0;
  logic          rd_valid = 1'b0;
  logic          out_valid_o;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data_o;
  logic          out_last_o;
  logic          out_buf_id_o;
  logic          busy_o;
  logic          done_pulse_o;
  logic          overrun_pulse_o;
  logic          overrun_sticky_o;

  logic [DW-1:0] ram_base = '0;
  int            ready_mode = 0;
  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            xfer_cnt = 0;
  int            done_cnt = 0;

  always #5 clk = ~clk;

  pingpong_buf_reader #(
    .DATA_WIDTH     (DW),
    .SAMPLES_PER_BUF(N),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .buf_ready_pulse_i(pulse),
    .buf_ready_id_i   (pulse_id),
    .rd_en_o          (rd_en_o),
    .rd_addr_o        (rd_addr_o),
    .rd_data_i        (rd_data),
    .rd_valid_i       (rd_valid),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready),
    .out_data_o       (out_data_o),
    .out_last_o       (out_last_o),
    .out_buf_id_o     (out_buf_id_o),
    .busy_o           (busy_o),
    .done_pulse_o     (done_pulse_o),
    .overrun_pulse_o  (overrun_pulse_o),
    .overrun_sticky_o (overrun_sticky_o)
  );

  // 1-cycle-latency RAM model; not reset, so a read issued during reset still returns.
  always @(posedge clk) begin
    rd_valid <= rd_en_o;
    rd_data  <= ram_base + DW'(rd_addr_o);
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  int            occ = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic          prev_id;

  always @(negedge clk) begin
    if (rst_i) begin
      occ        = 0;
      prev_stall = 1'b0;
    end else begin
      occ = occ + int'(rd_en_o) - int'(out_valid_o && out_ready);
      chk("occupancy_over_2", 32'(occ > 2), 32'd0);
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid_o), 32'd1);
        chk("stall_data", 32'(out_data_o), 32'(prev_data));
        chk("stall_tags", {30'd0, out_last_o, out_buf_id_o}, {30'd0, prev_last, prev_id});
      end
      if (done_pulse_o) done_cnt++;
      if (out_valid_o && out_ready) begin
        xfer_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %0h expected none", out_data_o);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sample_data", 32'(out_data_o), 32'(e.d));
          chk("sample_last", 32'(out_last_o), 32'(e.l));
          chk("sample_id", 32'(out_buf_id_o), 32'(e.id));
          chk("done_pulse", 32'(done_pulse_o), 32'(e.l));
        end
      end
      prev_stall = out_valid_o && !out_ready;
      prev_data  = out_data_o;
      prev_last  = out_last_o;
      prev_id    = out_buf_id_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller one cycle after the pulse was sampled.
  task automatic send_pulse(input logic id, input logic [DW-1:0] base, input bit accept);
    pulse    = 1'b1;
    pulse_id = id;
    if (accept) begin
      ram_base = base;
      for (int i = 0; i < int'(N); i++) begin
        exp_t e;
        e.d  = base + DW'(i);
        e.l  = (i == int'(N) - 1);
        e.id = id;
        q.push_back(e);
      end
    end
    tick();
    pulse = 1'b0;
  endtask

  task automatic wait_xfers(input int target);
    int n = 0;
    while (xfer_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    chk("xfer_wait_timeout", 32'(n < 2000), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || out_valid_o || busy_o) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < 3000), 32'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en_o), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr_o), 32'd0);
    chk({tag, "_data"}, 32'(out_data_o), 32'd0);
    chk({tag, "_tags"}, {30'd0, out_last_o, out_buf_id_o}, 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_pulse_o), 32'd0);
    chk({tag, "_overrun"}, {30'd0, overrun_pulse_o, overrun_sticky_o}, 32'd0);
  endtask

  initial begin
    int x0;
    int d0;
    int n;

    repeat (3) tick();
    rst_i = 1'b0;
    chk_quiet("reset");

    // Full-rate drain: latency and no bubbles.
    ready_mode = 0;
    x0 = xfer_cnt;
    d0 = done_cnt;
    send_pulse(1'b0, 16'hA000, 1'b1);
    chk("lat_rd_en", 32'(rd_en_o), 32'd1);
    chk("lat_rd_addr", 32'(rd_addr_o), 32'd0);
    chk("lat_busy", 32'(busy_o), 32'd1);
    tick();
    chk("lat_out_valid", 32'(out_valid_o), 32'd1);
    chk("lat_out_data", 32'(out_data_o), 32'hA000);
    repeat (N) tick();
    chk("full_rate_count", 32'(xfer_cnt - x0), 32'(N));
    chk("full_rate_done", 32'(done_cnt - d0), 32'd1);
    chk("full_rate_idle", 32'(busy_o), 32'd0);

    // Random backpressure with a long stall in the middle.
    ready_mode = 1;
    d0 = done_cnt;
    send_pulse(1'b0, 16'hA000, 1'b1);
    wait_xfers(xfer_cnt + 60);
    ready_mode = 2;
    repeat (20) tick();
    chk("stall_rd_en", 32'(rd_en_o), 32'd0);
    chk("stall_out_valid", 32'(out_valid_o), 32'd1);
    ready_mode = 1;
    wait_drain();
    chk("random_done", 32'(done_cnt - d0), 32'd1);

    // Back-to-back buffers: next pulse lands with the last transfer.
    ready_mode = 0;
    tick();
    d0 = done_cnt;
    send_pulse(1'b0, 16'hA000, 1'b1);
    n = 0;
    while (!(out_valid_o && out_last_o && out_ready) && n < 600) begin
      tick();
      n++;
    end
    chk("b2b_last_timeout", 32'(n < 600), 32'd1);
    send_pulse(1'b1, 16'hB000, 1'b1);
    chk("b2b_busy", 32'(busy_o), 32'd1);
    chk("b2b_rd_en", 32'(rd_en_o), 32'd1);
    chk("b2b_rd_addr", 32'(rd_addr_o), 32'd0);
    tick();
    chk("b2b_no_overrun", 32'(overrun_pulse_o), 32'd0);
    chk("b2b_first_data", 32'(out_data_o), 32'hB000);
    chk("b2b_first_id", 32'(out_buf_id_o), 32'd1);
    wait_drain();
    chk("b2b_done", 32'(done_cnt - d0), 32'd2);
    chk("b2b_sticky", 32'(overrun_sticky_o), 32'd0);

    // Overrun: second pulse mid-drain is dropped.
    ready_mode = 1;
    d0 = done_cnt;
    x0 = xfer_cnt;
    send_pulse(1'b0, 16'hA000, 1'b1);
    wait_xfers(x0 + 100);
    send_pulse(1'b1, 16'h0000, 1'b0);
    chk("overrun_pulse", 32'(overrun_pulse_o), 32'd1);
    chk("overrun_sticky", 32'(overrun_sticky_o), 32'd1);
    tick();
    chk("overrun_pulse_one_cycle", 32'(overrun_pulse_o), 32'd0);
    wait_drain();
    chk("overrun_drain_count", 32'(xfer_cnt - x0), 32'(N));
    chk("overrun_done", 32'(done_cnt - d0), 32'd1);
    repeat (10) tick();
    chk("overrun_no_second_busy", 32'(busy_o), 32'd0);
    chk("overrun_no_second_rd", 32'(rd_en_o), 32'd0);
    chk("overrun_sticky_holds", 32'(overrun_sticky_o), 32'd1);

    // Reset mid-drain, then a clean drain.
    x0 = xfer_cnt;
    send_pulse(1'b0, 16'hA000, 1'b1);
    wait_xfers(x0 + 50);
    rst_i = 1'b1;
    q.delete();
    tick();
    rst_i = 1'b0;
    chk_quiet("mid_reset");
    tick();
    ready_mode = 1;
    d0 = done_cnt;
    x0 = xfer_cnt;
    send_pulse(1'b1, 16'hB000, 1'b1);
    chk("post_reset_rd_addr", 32'(rd_addr_o), 32'd0);
    wait_drain();
    chk("post_reset_count", 32'(xfer_cnt - x0), 32'(N));
    chk("post_reset_done", 32'(done_cnt - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
